decodificador_ad_year_2dig: RTL and testbench

Converts a packed two-digit BCD year, as delivered by the RTC read path, back into a binary count for loading into the year counter, which itself produces BCD. Each accepted byte is validated digit by digit. Valid bytes go through a multi-cycle repeated-add conversion. The result is presented with a one-cycle load strobe. Invalid BCD is rejected with an error pulse and leaves the previous result untouched.

---
 rtl/decodificador_ad_year_2dig.sv | 79 +++++++
 tb/tb_decodificador_ad_year_2dig.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decodificador_ad_year_2dig.sv
// Packed two-digit BCD year to binary, with digit validation.
// Tens are folded in by repeated +10, then units are added once.
module decodificador_ad_year_2dig #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   datos_RTC,
    input  logic         dato_valido,
    output logic         listo,
    output logic [N-1:0] q_bin,
    output logic         carga,
    output logic         error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ACUM  = 2'd2;
    localparam logic [1:0] SUMA  = 2'd3;

    logic [1:0]   state;
    logic [3:0]   dec;
    logic [3:0]   uni;
    logic [3:0]   cnt;
    logic [N-1:0] acc;

    assign listo = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dec   <= '0;
            uni   <= '0;
            cnt   <= '0;
            acc   <= '0;
            q_bin <= '0;
            carga <= 1'b0;
            error <= 1'b0;
        end else begin
            carga <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dato_valido) begin
                        dec   <= datos_RTC[7:4];
                        uni   <= datos_RTC[3:0];
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // Bad digits leave acc and q_bin exactly as they were
                    if (dec > 4'd9 || uni > 4'd9) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        acc   <= '0;
                        cnt   <= dec;
                        state <= ACUM;
                    end
                end
                ACUM: begin
                    if (cnt == 4'd0) begin
                        state <= SUMA;
                    end else begin
                        acc <= acc + N'(10);
                        cnt <= cnt - 4'd1;
                    end
                end
                SUMA: begin
                    q_bin <= acc + {{(N-4){1'b0}}, uni};
                    carga <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decodificador_ad_year_2dig.sv
// Scoreboard bench for the BCD year decoder.
// Expected results are queued at acceptance and matched on strobes.
module tb_decodificador_ad_year_2dig;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] datos_RTC = 8'h00;
    logic       dato_valido = 1'b0;
    logic       listo;
    logic [6:0] q_bin;
    logic       carga;
    logic       error;

    decodificador_ad_year_2dig #(.N(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .datos_RTC   (datos_RTC),
        .dato_valido (dato_valido),
        .listo       (listo),
        .q_bin       (q_bin),
        .carga       (carga),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_q = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    endtask

    // Strobe monitor: every carga/error must match the head of the queue
    always @(negedge clk) begin
        if (reset && (carga || error)) begin
            exp_t it;
            if (carga && error) check("exclusive", 1, 0);
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                it = exp_q.pop_front();
                check("kind_err", int'(error), int'(it.err));
                check("latency", cyc, it.due);
                check("listo_on_strobe", int'(listo), 1);
                if (!it.err) begin
                    check("q_bin", int'(q_bin), it.val);
                    last_q = it.val;
                end else begin
                    check("q_hold_err", int'(q_bin), last_q);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        int t;
        int u;
        bit ok;
        exp_t it;
        t = int'(d[7:4]);
        u = int'(d[3:0]);
        datos_RTC   = d;
        dato_valido = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (listo) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            it.err = (t > 9) || (u > 9);
            it.val = 10 * t + u;
            it.due = it.err ? cyc + 2 : cyc + 4 + t;
            exp_q.push_back(it);
        end
        @(posedge clk);
        #1;
        if (!hold) dato_valido = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", int'(q_bin), 0);
        check("rst_carga", int'(carga), 0);
        check("rst_error", int'(error), 0);
        check("rst_listo", int'(listo), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_listo", int'(listo), 1);
        check("idle_q", int'(q_bin), 0);

        send(8'h00, 1'b0);
        wait_idle();

        // T=9 keeps listo low for 12 cycles
        send(8'h99, 1'b0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (listo) break;
            n++;
        end
        check("busy_99", n, 12);
        wait_idle();
        check("q_99", int'(q_bin), 99);

        // Full back-to-back sweep
        for (int t = 0; t < 10; t++)
            for (int u = 0; u < 10; u++)
                send({4'(t), 4'(u)}, 1'b1);
        dato_valido = 1'b0;
        wait_idle();

        send(8'h57, 1'b0);
        wait_idle();
        send(8'h4A, 1'b0);
        send(8'hA3, 1'b0);
        wait_idle();
        check("q_keep_57", int'(q_bin), 57);

        // Request while busy is ignored
        send(8'h80, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        datos_RTC   = 8'h12;
        dato_valido = 1'b1;
        @(posedge clk);
        #1;
        dato_valido = 1'b0;
        wait_idle();
        check("q_80", int'(q_bin), 80);
        repeat (4) @(posedge clk);
        #1;
        check("q_80_hold", int'(q_bin), 80);

        // Reset mid-conversion
        send(8'h80, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_q", int'(q_bin), 0);
        check("mid_rst_listo", int'(listo), 1);
        check("mid_rst_carga", int'(carga), 0);
        exp_q.delete();
        last_q = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_q", int'(q_bin), 0);
        check("left_over", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
